// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard-control definitions: deadline/latency encodings and producer record layout.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a; imported by hazard_ctrl, md_busy_counter and the tuse/tnew decoders.
package hazard_ctrl_pkg;

    // rs_tuse / rt_tuse value meaning "this operand is not read"
    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Cycles after E entry until a result can be forwarded
    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Producer record carried by the E and M stages
    typedef struct packed {
        logic [4:0] wa;    // destination GPR, 0 = none
        logic [1:0] tnew;  // cycles remaining until forwardable
        logic       epc;   // instruction is mtc0 writing EPC
    } prod_rec_t;

    localparam prod_rec_t REC_BUBBLE = '{wa: 5'd0, tnew: 2'd0, epc: 1'b0};

    // tnew ages by one per stage, bottoming out at "ready now"
    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // One source operand against the in-flight producers. The E record is
    // the youngest writer of the register, so when it matches it alone
    // decides; an older M value for the same register is dead.
    function automatic logic src_hazard(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input prod_rec_t  e,
                                        input prod_rec_t  m);
        if (src == REG_ZERO || tuse == TUSE_NONE) return 1'b0;
        if (e.wa == src) return e.tnew > tuse;
        if (m.wa == src) return m.tnew > tuse;
        return 1'b0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div busy counter: loads the operation length on start, counts down to zero.
// Latency: busy rises the cycle after start and stays high for exactly the loaded count.
// Backpressure: none; a new start always reloads, and only reset clears an operation.
// Ports: clk, reset (async active-low), start, is_div (qualifies start), busy (count != 0).
module md_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall controller: tracks E/M producer records and raises a single same-cycle stall.
// Latency: stall is combinational from D inputs and current records; records advance every edge.
// Backpressure: stall freezes PC and F/D and injects a bubble into E; flush empties E and M.
// Ports: clk, reset (async active-low); D-stage rs/rt/tuse/wa/tnew/md/mtc0-epc/eret fields;
//        e_md_start/e_md_is_div; flush; outputs stall, e_wa/e_tnew, m_wa/m_tnew, md_busy.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_is_md,
    input  logic       d_is_mtc0_epc,
    input  logic       d_is_eret,
    input  logic       e_md_start,
    input  logic       e_md_is_div,
    input  logic       flush,
    output logic       stall,
    output logic [4:0] e_wa,
    output logic [1:0] e_tnew,
    output logic [4:0] m_wa,
    output logic [1:0] m_tnew,
    output logic       md_busy
);

    prod_rec_t d_rec;
    prod_rec_t e_rec;
    prod_rec_t m_rec;

    logic data_stall;
    logic md_stall;
    logic epc_stall;

    // A record with no GPR destination carries no data latency; the EPC
    // flag is kept because mtc0 itself has no GPR destination.
    always_comb begin
        d_rec      = REC_BUBBLE;
        d_rec.wa   = d_wa;
        d_rec.tnew = (d_wa == REG_ZERO) ? TNEW_LINK : d_tnew;
        d_rec.epc  = d_is_mtc0_epc;
    end

    assign data_stall = src_hazard(d_rs, d_rs_tuse, e_rec, m_rec)
                      | src_hazard(d_rt, d_rt_tuse, e_rec, m_rec);
    // The starting operation counts too: the counter only shows it next cycle.
    assign md_stall   = d_is_md & (md_busy | e_md_start);
    // eret must not read EPC while an mtc0 to EPC is still in flight.
    assign epc_stall  = d_is_eret & (e_rec.epc | m_rec.epc);
    assign stall      = data_stall | md_stall | epc_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rec <= REC_BUBBLE;
            m_rec <= REC_BUBBLE;
        end else if (flush) begin
            e_rec <= REC_BUBBLE;
            m_rec <= REC_BUBBLE;
        end else begin
            m_rec.wa   <= e_rec.wa;
            m_rec.tnew <= tnew_step(e_rec.tnew);
            m_rec.epc  <= e_rec.epc;
            e_rec      <= stall ? REC_BUBBLE : d_rec;
        end
    end

    assign e_wa   = e_rec.wa;
    assign e_tnew = e_rec.tnew;
    assign m_wa   = m_rec.wa;
    assign m_tnew = m_rec.tnew;

    // Flush deliberately does not reach the counter: an issued mult/div
    // keeps running and still owns HI/LO.
    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_is_div),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_rs_tuse;
    logic [1:0] d_rt_tuse;
    logic [4:0] d_wa;
    logic [1:0] d_tnew;
    logic       d_is_md;
    logic       d_is_mtc0_epc;
    logic       d_is_eret;
    logic       e_md_start;
    logic       e_md_is_div;
    logic       flush;
    logic       stall;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       md_busy;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .d_rs          (d_rs),
        .d_rt          (d_rt),
        .d_rs_tuse     (d_rs_tuse),
        .d_rt_tuse     (d_rt_tuse),
        .d_wa          (d_wa),
        .d_tnew        (d_tnew),
        .d_is_md       (d_is_md),
        .d_is_mtc0_epc (d_is_mtc0_epc),
        .d_is_eret     (d_is_eret),
        .e_md_start    (e_md_start),
        .e_md_is_div   (e_md_is_div),
        .flush         (flush),
        .stall         (stall),
        .e_wa          (e_wa),
        .e_tnew        (e_tnew),
        .m_wa          (m_wa),
        .m_tnew        (m_tnew),
        .md_busy       (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall;
        logic [4:0] e_wa;
        logic [1:0] e_tnew;
        logic [4:0] m_wa;
        logic [1:0] m_tnew;
        logic       md_busy;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;

    task automatic d_clear();
        d_rs = 5'd0; d_rt = 5'd0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
        d_wa = 5'd0; d_tnew = 2'd0; d_is_md = 1'b0; d_is_mtc0_epc = 1'b0;
        d_is_eret = 1'b0; e_md_start = 1'b0; e_md_is_div = 1'b0; flush = 1'b0;
    endtask

    task automatic push_exp(input string tag, input logic s, input logic [4:0] ew,
                            input logic [1:0] et, input logic [4:0] mw,
                            input logic [1:0] mt, input logic b);
        obs_t o;
        o.stall = s; o.e_wa = ew; o.e_tnew = et; o.m_wa = mw; o.m_tnew = mt; o.md_busy = b;
        exp_q.push_back(o);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        obs_t  o;
        string t;
        o = exp_q.pop_front();
        t = tag_q.pop_front();
        tests_run += 6;
        assert (stall === o.stall) else begin
            tests_failed++; $error("FAIL %s stall got %b want %b", t, stall, o.stall); end
        assert (e_wa === o.e_wa) else begin
            tests_failed++; $error("FAIL %s e_wa got %0d want %0d", t, e_wa, o.e_wa); end
        assert (e_tnew === o.e_tnew) else begin
            tests_failed++; $error("FAIL %s e_tnew got %0d want %0d", t, e_tnew, o.e_tnew); end
        assert (m_wa === o.m_wa) else begin
            tests_failed++; $error("FAIL %s m_wa got %0d want %0d", t, m_wa, o.m_wa); end
        assert (m_tnew === o.m_tnew) else begin
            tests_failed++; $error("FAIL %s m_tnew got %0d want %0d", t, m_tnew, o.m_tnew); end
        assert (md_busy === o.md_busy) else begin
            tests_failed++; $error("FAIL %s md_busy got %b want %b", t, md_busy, o.md_busy); end
    endtask

    // Expect values mid-cycle (inputs were driven just after posedge), then advance.
    task automatic cyc(input string tag, input logic s, input logic [4:0] ew,
                       input logic [1:0] et, input logic [4:0] mw,
                       input logic [1:0] mt, input logic b);
        push_exp(tag, s, ew, et, mw, mt, b);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        d_clear();
        #2;
        push_exp("reset", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        pop_check();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // lw $1 then dependent addu (tuse 1)
        d_clear(); d_wa = 5'd1; d_tnew = 2'd2; d_rs = 5'd2; d_rs_tuse = 2'd1;
        cyc("lw_issue", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        d_clear(); d_rs = 5'd1; d_rs_tuse = 2'd1; d_rt = 5'd5; d_rt_tuse = 2'd1;
        d_wa = 5'd4; d_tnew = 2'd1;
        cyc("ldu_stall", 1'b1, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0);
        cyc("ldu_release", 1'b0, 5'd0, 2'd0, 5'd1, 2'd1, 1'b0);

        // lw $1 then beq $1 (tuse 0): two stall cycles
        d_clear(); d_wa = 5'd1; d_tnew = 2'd2;
        cyc("lw2_issue", 1'b0, 5'd4, 2'd1, 5'd0, 2'd0, 1'b0);
        d_clear(); d_rs = 5'd1; d_rs_tuse = 2'd0; d_rt_tuse = 2'd0;
        cyc("beq_stall1", 1'b1, 5'd1, 2'd2, 5'd4, 2'd0, 1'b0);
        cyc("beq_stall2", 1'b1, 5'd0, 2'd0, 5'd1, 2'd1, 1'b0);
        cyc("beq_go", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);

        // same with rs = $0: never a hazard
        d_clear(); d_wa = 5'd1; d_tnew = 2'd2;
        cyc("lw3_issue", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        d_clear(); d_rs_tuse = 2'd0; d_rt_tuse = 2'd0;
        cyc("beq_r0", 1'b0, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0);

        // E and M both write $3 (E tnew 1, M tnew 0)
        d_clear(); d_wa = 5'd3; d_tnew = 2'd1;
        cyc("alu3_a", 1'b0, 5'd0, 2'd0, 5'd1, 2'd1, 1'b0);
        cyc("alu3_b", 1'b0, 5'd3, 2'd1, 5'd0, 2'd0, 1'b0);
        d_rs = 5'd3; d_rs_tuse = 2'd1;
        cyc("both_tuse1", 1'b0, 5'd3, 2'd1, 5'd3, 2'd0, 1'b0);
        d_clear(); d_rs = 5'd3; d_rs_tuse = 2'd0;
        cyc("both_tuse0", 1'b1, 5'd3, 2'd1, 5'd3, 2'd0, 1'b0);
        cyc("both_go", 1'b0, 5'd0, 2'd0, 5'd3, 2'd0, 1'b0);

        // E (tnew 0) shadows an older M load of the same register (tnew 1)
        d_clear(); d_wa = 5'd3; d_tnew = 2'd2;
        cyc("prio_lw", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        d_clear(); d_wa = 5'd3; d_tnew = 2'd0;
        cyc("prio_lui", 1'b0, 5'd3, 2'd2, 5'd0, 2'd0, 1'b0);
        d_clear(); d_rs = 5'd3; d_rs_tuse = 2'd0;
        cyc("prio_e_wins", 1'b0, 5'd3, 2'd0, 5'd3, 2'd1, 1'b0);

        // div start with mflo in D: 11 stall cycles, flush mid-div keeps busy
        d_clear(); d_is_md = 1'b1; d_wa = 5'd2; d_tnew = 2'd1;
        e_md_start = 1'b1; e_md_is_div = 1'b1;
        cyc("div_start", 1'b1, 5'd0, 2'd0, 5'd3, 2'd0, 1'b0);
        e_md_start = 1'b0; e_md_is_div = 1'b0;
        for (int i = 0; i < 10; i++) begin
            flush = (i == 3);
            cyc($sformatf("div_busy%0d", i), 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1);
        end
        flush = 1'b0;
        cyc("div_done", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);

        // mult: 6 stall cycles
        d_clear(); d_is_md = 1'b1; e_md_start = 1'b1;
        cyc("mul_start", 1'b1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b0);
        e_md_start = 1'b0;
        cyc("mul_busy0", 1'b1, 5'd0, 2'd0, 5'd2, 2'd0, 1'b1);
        for (int i = 1; i < 5; i++) begin
            cyc($sformatf("mul_busy%0d", i), 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1);
        end
        cyc("mul_done", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);

        // mtc0 EPC then eret: 2 stall cycles
        d_clear(); d_is_mtc0_epc = 1'b1;
        cyc("mtc0_issue", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        d_clear(); d_is_eret = 1'b1;
        cyc("eret_stall1", 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        cyc("eret_stall2", 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        cyc("eret_go", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);

        // flush while mtc0 sits in M clears the EPC interlock
        d_clear(); d_is_mtc0_epc = 1'b1;
        cyc("mtc0b_issue", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        d_clear();
        cyc("mtc0b_nop", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        d_clear(); d_is_eret = 1'b1; flush = 1'b1;
        cyc("eret_flush", 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        flush = 1'b0;
        cyc("eret_after_flush", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);

        // async reset mid-div with a load-use hazard pending
        d_clear(); d_wa = 5'd1; d_tnew = 2'd2; e_md_start = 1'b1; e_md_is_div = 1'b1;
        cyc("rst_setup", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        d_clear(); d_rs = 5'd1; d_rs_tuse = 2'd1; d_wa = 5'd4; d_tnew = 2'd1;
        push_exp("rst_pre", 1'b1, 5'd1, 2'd2, 5'd0, 2'd0, 1'b1);
        @(negedge clk);
        pop_check();
        #1;
        reset = 1'b0;
        #1;
        push_exp("rst_async", 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        pop_check();
        #1;
        reset = 1'b1;
        d_clear();
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall controller for the 5-stage MIPS pipeline (F/D/E/M/W) with CP0 and a multi-cycle mult/div unit.
- Consumes the D-stage register-use deadlines (rs_tuse/rt_tuse, 3 = no use) from the per-instruction tuse decoder.
- Tracks producer records for the E and M stages internally: destination register, tnew, mtc0-EPC flag.
- Owns the mult/div busy counter. Drives the single stall signal (freeze PC and F/D, bubble into E) and exposes producer records to the forwarding muxes.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- d_rs  in  5  D-stage rs field
- d_rt  in  5  D-stage rt field
- d_rs_tuse  in  2  rs deadline in cycles from D; 3 = not read
- d_rt_tuse  in  2  rt deadline; 3 = not read
- d_wa  in  5  D-stage destination register, 0 = none
- d_tnew  in  2  cycles after E entry until result forwardable (ALU 1, load 2, jal/lui-style 0)
- d_is_md  in  1  D instruction uses HI/LO or the md unit (mult*, div*, mf/mthi/lo)
- d_is_mtc0_epc  in  1  D is mtc0 targeting EPC (reg 14)
- d_is_eret  in  1  D is eret
- e_md_start  in  1  E-stage mult/div issuing this cycle
- e_md_is_div  in  1  qualifies e_md_start
- flush  in  1  exception/eret flush from CP0 (M stage)
- stall  out  1  freeze PC and F/D; insert bubble into E
- e_wa  out  5  E record destination
- e_tnew  out  2  E record remaining tnew
- m_wa  out  5  M record destination
- m_tnew  out  2  M record remaining tnew
- md_busy  out  1  mult/div counter non-zero

Behaviour:
- Reset (reset=0, asynchronous): E and M records cleared (wa=0, tnew=0, epc flag 0); busy counter 0. All outputs therefore 0.
- Record advance, every clk edge:
  - M <= E, with tnew decremented and saturating at 0.
  - E <= D-stage fields when stall=0, else bubble (wa=0, tnew=0, flag 0).
- Flush has priority over advance: both E and M load as bubbles.
- Data stall, rs side: d_rs_tuse != 3, d_rs != 0, and (e_wa==d_rs with e_tnew>d_rs_tuse, or m_wa==d_rs with m_tnew>d_rs_tuse). rt side is identical with rt fields. Comparisons are unsigned 2-bit. When both E and M match, the E record governs (youngest producer).
- MD stall: d_is_md and (md_busy or e_md_start).
- EPC stall: d_is_eret and (E.epc flag or M.epc flag).
- stall = OR of the data, MD and EPC conditions. It is purely combinational from current inputs and records (same-cycle).
- Busy counter:
  - On e_md_start it loads DIV_CYCLES when e_md_is_div, else MULT_CYCLES.
  - Otherwise it decrements to 0.
  - Load wins over decrement.
  - flush does NOT cancel a started operation.
  - md_busy = (count != 0). Width is clog2(DIV_CYCLES+1).
- Register 0 is never a hazard. d_wa=0 records behave exactly as bubbles.
- Reset asserted mid-operation clears the busy counter immediately. stall drops to whatever the current D inputs imply against empty records.

Decomposition:
- Shared package/header: TUSE_NONE=3, register-0 constant, MULT_CYCLES/DIV_CYCLES defaults, and the record layout {wa[4:0], tnew[1:0], epc}. Tnew constants (TNEW_ALU=1, TNEW_LOAD=2, TNEW_LINK=0) go in the same header so the decoders share it.
- One natural sub-module: md_busy_counter (load/decrement counter and busy flag). Keep it separate so the mult/div datapath can reuse it.

Test Plan:
- lw $1 in E (tnew 2), D = addu reading $1 with rs_tuse 1 -> stall=1. Next cycle: M.tnew=1, E=bubble, stall=0.
- lw $1 in E, D = beq $1 with tuse 0 -> stall 2 cycles, then stall=0. Repeat with d_rs=0 -> no stall.
- Both E and M write $3 (E tnew 1, M tnew 0), D reads $3 with tuse 1 -> no stall. Same with tuse 0 -> stall 1 cycle.
- e_md_start with e_md_is_div=1, D = mflo -> stall for exactly 11 cycles (start cycle + 10 busy). Mult -> 6 cycles. flush mid-div keeps md_busy=1.
- mtc0 EPC in E, D = eret -> stall 2 cycles. flush while mtc0 in M -> records cleared, stall=0 next cycle.
- Assert reset asynchronously mid-div with a load hazard pending -> md_busy, all record outputs and stall go to 0 without waiting for a clk edge.
